// File: rtl/debug_controller.sv
// Debug controller: byte-oriented command port driving probe reads,
// single-stepping, free-run with one hardware breakpoint, and a
// registered byte response channel back to the host.
module debug_controller #(
  parameter int NUM_PROBES = 32,
  parameter int PROBE_W    = 32,
  parameter int PC_W       = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [7:0]                    cmd_code,
  output logic                          cmd_ready,
  input  logic [NUM_PROBES*PROBE_W-1:0] probe_bus,
  input  logic [PC_W-1:0]               pc_in,
  output logic                          cpu_en,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  input  logic                          tx_ready,
  output logic                          halted
);

  // FSM encoding kept as plain constants for compatibility with older tools
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd1;
  localparam logic [2:0] ST_STEP    = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_BP_LOAD = 3'd4;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_BP   = 2'b11;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_BP  = 8'hBB;

  // Bytes remaining after the first one of a probe response
  localparam logic [7:0] READ_LEFT = 8'(PROBE_W / 8 - 1);
  // Index of the final breakpoint address byte
  localparam logic [7:0] BP_LAST   = 8'(PC_W / 8 - 1);

  // Registered state
  logic [2:0]         state_r;
  logic               cmd_ready_r;
  logic               halted_r;
  logic               tx_valid_r;
  logic [7:0]         tx_data_r;
  logic [PROBE_W-1:0] resp_r;       // bytes still to be shifted out
  logic [7:0]         left_r;       // bytes still to send after tx_data_r
  logic               run_after_r;  // response ends by entering RUN
  logic [5:0]         step_cnt_r;   // processor cycles left in STEP
  logic [7:0]         bp_cnt_r;     // breakpoint byte index while loading
  logic [PC_W-1:0]    bp_addr_r;
  logic               bp_armed_r;

  // Decoded / next-state signals
  logic [2:0]         state_next_s;
  logic               accept_s;
  logic [1:0]         opcode_s;
  logic [5:0]         arg_s;
  logic               bp_hit_s;
  logic               tx_fire_s;
  logic [PROBE_W-1:0] probe_sel_s;
  logic               load_send_s;
  logic [PROBE_W-1:0] send_word_s;
  logic [7:0]         send_left_s;
  logic               send_run_s;
  logic               cpu_en_s;

  assign accept_s  = cmd_valid & cmd_ready_r;
  assign opcode_s  = cmd_code[7:6];
  assign arg_s     = cmd_code[5:0];
  assign bp_hit_s  = bp_armed_r & (pc_in == bp_addr_r);
  assign tx_fire_s = tx_valid_r & tx_ready;

  // Probe multiplexer; out-of-range arguments read as zero
  always_comb begin
    probe_sel_s = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      probe_sel_s = (arg_s == 6'(i)) ? probe_bus[i*PROBE_W +: PROBE_W] : probe_sel_s;
    end
  end

  // Next-state logic and response-load decode
  always_comb begin
    state_next_s = state_r;
    load_send_s  = 1'b0;
    send_word_s  = '0;
    send_left_s  = 8'd0;
    send_run_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (opcode_s)
            OP_READ: begin
              load_send_s = 1'b1;
              send_word_s = probe_sel_s;
              send_left_s = READ_LEFT;
            end
            OP_STEP: begin
              state_next_s = ST_STEP;
            end
            OP_RUN: begin
              load_send_s      = 1'b1;
              send_word_s[7:0] = RESP_ACK;
              send_run_s       = arg_s[0];
            end
            OP_BP: begin
              if (arg_s[0]) begin
                state_next_s = ST_BP_LOAD;
              end else begin
                load_send_s      = 1'b1;
                send_word_s[7:0] = RESP_ACK;
              end
            end
            default: begin
              state_next_s = ST_IDLE;
            end
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (step_cnt_r <= 6'd1) begin
          load_send_s      = 1'b1;
          send_word_s[7:0] = RESP_ACK;
        end else begin
          state_next_s = ST_STEP;
        end
      end
      ST_RUN: begin
        // A breakpoint hit takes priority over a HALT accepted the same cycle
        if (bp_hit_s) begin
          load_send_s      = 1'b1;
          send_word_s[7:0] = RESP_BP;
        end else if (accept_s && (opcode_s == OP_RUN) && !arg_s[0]) begin
          load_send_s      = 1'b1;
          send_word_s[7:0] = RESP_ACK;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_BP_LOAD: begin
        if (accept_s && (bp_cnt_r == BP_LAST)) begin
          load_send_s      = 1'b1;
          send_word_s[7:0] = RESP_ACK;
        end else begin
          state_next_s = ST_BP_LOAD;
        end
      end
      ST_SEND: begin
        if (tx_fire_s && (left_r == 8'd0)) begin
          state_next_s = run_after_r ? ST_RUN : ST_IDLE;
        end else begin
          state_next_s = ST_SEND;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    if (load_send_s) begin
      state_next_s = ST_SEND;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // Processor clock-enable: stepping, or running until the PC hits the breakpoint
  always_comb begin
    if (state_r == ST_STEP) begin
      cpu_en_s = 1'b1;
    end else if (state_r == ST_RUN) begin
      cpu_en_s = ~bp_hit_s;
    end else begin
      cpu_en_s = 1'b0;
    end
  end

  // State register with registered ready/halted decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      halted_r    <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      cmd_ready_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_RUN) ||
                     (state_next_s == ST_BP_LOAD);
      halted_r    <= (state_next_s != ST_RUN);
    end
  end

  // Response byte path: load a new response or advance on each consumed byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 8'd0;
      resp_r      <= '0;
      left_r      <= 8'd0;
      run_after_r <= 1'b0;
    end else if (load_send_s) begin
      tx_valid_r  <= 1'b1;
      tx_data_r   <= send_word_s[7:0];
      resp_r      <= send_word_s >> 8;
      left_r      <= send_left_s;
      run_after_r <= send_run_s;
    end else if ((state_r == ST_SEND) && tx_fire_s) begin
      if (left_r == 8'd0) begin
        tx_valid_r  <= 1'b0;
        tx_data_r   <= 8'd0;
        resp_r      <= '0;
        run_after_r <= 1'b0;
      end else begin
        tx_data_r <= resp_r[7:0];
        resp_r    <= resp_r >> 8;
        left_r    <= left_r - 8'd1;
      end
    end else begin
      tx_valid_r <= tx_valid_r;
    end
  end

  // Step counter: loaded on STEP acceptance, counts down one per enabled cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt_r <= 6'd0;
    end else if ((state_r == ST_IDLE) && accept_s && (opcode_s == OP_STEP)) begin
      step_cnt_r <= (arg_s == 6'd0) ? 6'd1 : arg_s;
    end else if (state_r == ST_STEP) begin
      step_cnt_r <= step_cnt_r - 6'd1;
    end else begin
      step_cnt_r <= step_cnt_r;
    end
  end

  // Breakpoint register: cleared or loaded byte-by-byte, LSB first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_addr_r  <= '0;
      bp_armed_r <= 1'b0;
      bp_cnt_r   <= 8'd0;
    end else if ((state_r == ST_IDLE) && accept_s && (opcode_s == OP_BP)) begin
      bp_cnt_r <= 8'd0;
      if (!arg_s[0]) begin
        bp_armed_r <= 1'b0;
      end else begin
        bp_armed_r <= bp_armed_r;
      end
    end else if ((state_r == ST_BP_LOAD) && accept_s) begin
      for (int i = 0; i < PC_W / 8; i++) begin
        if (bp_cnt_r == 8'(i)) begin
          bp_addr_r[i*8 +: 8] <= cmd_code;
        end else begin
          bp_addr_r[i*8 +: 8] <= bp_addr_r[i*8 +: 8];
        end
      end
      if (bp_cnt_r == BP_LAST) begin
        bp_armed_r <= 1'b1;
        bp_cnt_r   <= 8'd0;
      end else begin
        bp_cnt_r <= bp_cnt_r + 8'd1;
      end
    end else begin
      bp_cnt_r <= bp_cnt_r;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign halted    = halted_r;
  assign tx_valid  = tx_valid_r;
  assign tx_data   = tx_data_r;
  assign cpu_en    = cpu_en_s;

endmodule

// File: tb/tb_debug_controller.sv
// Directed testbench for debug_controller with a simple processor PC model.
module tb_debug_controller;

  localparam int NP  = 32;
  localparam int PW  = 32;
  localparam int PCW = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [7:0]       cmd_code = 8'd0;
  logic             cmd_ready;
  logic [NP*PW-1:0] probe_bus;
  logic [PCW-1:0]   pc_in = '0;
  logic             cpu_en;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready = 1'b1;
  logic             halted;
  logic             pc_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  debug_controller #(.NUM_PROBES(NP), .PROBE_W(PW), .PC_W(PCW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .probe_bus(probe_bus), .pc_in(pc_in), .cpu_en(cpu_en),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  // Processor model: PC advances by 4 on every enabled cycle
  always @(posedge clk) begin
    if (pc_clr) pc_in <= '0;
    else if (cpu_en) pc_in <= pc_in + 32'd4;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] c);
    cmd_valid = 1'b1;
    cmd_code  = c;
    chk({tag, "_rdy"}, {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_code  = 8'd0;
  endtask

  // Consume n bytes with tx_ready high and compare LSB-first against exp
  task automatic expect_bytes(input string tag, input int n, input logic [63:0] exp);
    logic [63:0] e;
    e = exp;
    tx_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 40 && !tx_valid; c++) tick();
      if (!tx_valid) begin
        chk({tag, "_timeout"}, {63'd0, tx_valid}, 64'd1);
        return;
      end
      chk(tag, {56'd0, tx_data}, {56'd0, e[k*8 +: 8]});
      tick();
    end
    chk({tag, "_done"}, {63'd0, tx_valid}, 64'd0);
  endtask

  task automatic clear_pc();
    pc_clr = 1'b1;
    tick();
    pc_clr = 1'b0;
  endtask

  int n_en;
  int n_tx;
  logic seen;

  initial begin
    for (int i = 0; i < NP; i++) probe_bus[i*PW +: PW] = 32'h1000_0000 + 32'(i) * 32'h101;
    probe_bus[5*PW +: PW] = 32'h1234_5678;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b0;
    #2;
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_tx_data", {56'd0, tx_data}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd1);
    chk("rst_cpu_en", {63'd0, cpu_en}, 64'd0);
    pc_clr = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    pc_clr = 1'b0;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // READ probe 5 under backpressure, then drain
    tx_ready = 1'b0;
    send_cmd("read5", 8'h05);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", {63'd0, tx_valid}, 64'd1);
      chk("bp_hold_data", {56'd0, tx_data}, 64'h78);
      chk("bp_hold_rdy", {63'd0, cmd_ready}, 64'd0);
      tick();
    end
    expect_bytes("read5", 4, 64'h1234_5678);
    chk("read5_idle_rdy", {63'd0, cmd_ready}, 64'd1);
    chk("read5_halted", {63'd0, halted}, 64'd1);

    // READ out of range and the last valid probe
    send_cmd("read3f", 8'h3F);
    expect_bytes("read3f", 4, 64'h0);
    send_cmd("read1f", 8'h1F);
    expect_bytes("read1f", 4, 64'h1000_1F1F);

    // STEP 3 and STEP 0 (treated as 1)
    send_cmd("step3", 8'h43);
    chk("step3_first", {63'd0, cpu_en}, 64'd1);
    n_en = 0;
    for (int c = 0; c < 20 && !tx_valid; c++) begin
      if (cpu_en) n_en++;
      tick();
    end
    chk("step3_count", 64'(n_en), 64'd3);
    expect_bytes("step3", 1, 64'hA5);
    send_cmd("step0", 8'h40);
    n_en = 0;
    for (int c = 0; c < 20 && !tx_valid; c++) begin
      if (cpu_en) n_en++;
      tick();
    end
    chk("step0_count", 64'(n_en), 64'd1);
    expect_bytes("step0", 1, 64'hA5);

    // Breakpoint at 0x40, RUN from PC 0
    send_cmd("bp_cmd", 8'hC1);
    send_cmd("bp_b0", 8'h40);
    send_cmd("bp_b1", 8'h00);
    send_cmd("bp_b2", 8'h00);
    send_cmd("bp_b3", 8'h00);
    expect_bytes("bp_ack", 1, 64'hA5);
    clear_pc();
    send_cmd("run", 8'h81);
    expect_bytes("run_ack", 1, 64'hA5);
    chk("run_halted", {63'd0, halted}, 64'd0);
    chk("run_cpu_en", {63'd0, cpu_en}, 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (!halted && pc_in == 32'h40) seen = 1'b1;
    end
    chk("bp_reach", {63'd0, seen}, 64'd1);
    chk("bp_cpu_en_low", {63'd0, cpu_en}, 64'd0);
    expect_bytes("bp_hit", 1, 64'hBB);
    chk("bp_pc", 64'(pc_in), 64'h40);
    chk("bp_halted", {63'd0, halted}, 64'd1);

    // Disarm, RUN, discarded command, then HALT
    send_cmd("bp_clr", 8'hC0);
    expect_bytes("bp_clr", 1, 64'hA5);
    clear_pc();
    send_cmd("run2", 8'h81);
    expect_bytes("run2_ack", 1, 64'hA5);
    tick();
    send_cmd("run2_discard", 8'h05);
    chk("discard_no_tx", {63'd0, tx_valid}, 64'd0);
    chk("discard_running", {63'd0, halted}, 64'd0);
    for (int c = 0; c < 20; c++) tick();
    chk("disarmed_no_tx", {63'd0, tx_valid}, 64'd0);
    send_cmd("halt", 8'h80);
    chk("halt_cpu_en", {63'd0, cpu_en}, 64'd0);
    chk("halt_halted", {63'd0, halted}, 64'd1);
    expect_bytes("halt", 1, 64'hA5);

    // HALT accepted in the same cycle as a breakpoint match at 0x08
    send_cmd("bp8_cmd", 8'hC1);
    send_cmd("bp8_b0", 8'h08);
    send_cmd("bp8_b1", 8'h00);
    send_cmd("bp8_b2", 8'h00);
    send_cmd("bp8_b3", 8'h00);
    expect_bytes("bp8_ack", 1, 64'hA5);
    clear_pc();
    send_cmd("run3", 8'h81);
    expect_bytes("run3_ack", 1, 64'hA5);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (!halted && pc_in == 32'h08) seen = 1'b1;
      else tick();
    end
    chk("sim_reach", {63'd0, seen}, 64'd1);
    send_cmd("sim_halt", 8'h80);
    expect_bytes("sim_bb", 1, 64'hBB);
    chk("sim_halted", {63'd0, halted}, 64'd1);

    // Reset in the middle of a 10-cycle STEP
    send_cmd("step10", 8'h4A);
    tick();
    tick();
    tick();
    chk("step10_mid", {63'd0, cpu_en}, 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_cpu_en", {63'd0, cpu_en}, 64'd0);
    chk("mid_rst_halted", {63'd0, halted}, 64'd1);
    chk("mid_rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    n_tx = 0;
    for (int c = 0; c < 15; c++) begin
      if (tx_valid) n_tx++;
      tick();
    end
    chk("mid_rst_no_byte", 64'(n_tx), 64'd0);
    // Breakpoint at 0x08 must be disarmed by reset
    clear_pc();
    send_cmd("run4", 8'h81);
    expect_bytes("run4_ack", 1, 64'hA5);
    for (int c = 0; c < 20; c++) tick();
    chk("rst_disarm_no_tx", {63'd0, tx_valid}, 64'd0);
    chk("rst_disarm_running", {63'd0, halted}, 64'd0);
    chk("rst_disarm_pc_past", {63'd0, (pc_in > 32'h08)}, 64'd1);
    send_cmd("halt4", 8'h80);
    expect_bytes("halt4", 1, 64'hA5);
    chk("final_halted", {63'd0, halted}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/debug_controller.md
DEBUG_CONTROLLER -- requirements
Module: debug_controller

Interface
REQ-001 SHALL have parameter NUM_PROBES, default 32, number of probe channels (1..64).
REQ-002 SHALL have parameter PROBE_W, default 32, bits per probe (multiple of 8, 8..64).
REQ-003 SHALL have parameter PC_W, default 32, breakpoint/PC width (multiple of 8).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command byte present.
REQ-007 cmd_code  in  8  command: [7:6] opcode, [5:0] argument.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-009 probe_bus  in  NUM_PROBES*PROBE_W  flattened probes; probe i at bits [i*PROBE_W +: PROBE_W].
REQ-010 pc_in  in  PC_W  current processor PC.
REQ-011 cpu_en  out  1  processor clock-enable; one processor cycle per high clk cycle.
REQ-012 tx_valid  out  1  response byte present.
REQ-013 tx_data  out  8  response byte.
REQ-014 tx_ready  in  1  byte consumed when tx_valid && tx_ready.
REQ-015 halted  out  1  high whenever state is not RUN.

Function
REQ-016 SHALL implement states IDLE, SEND, STEP, RUN, BP_LOAD.
REQ-017 cmd_ready SHALL be 1 in IDLE, RUN, BP_LOAD; 0 in SEND, STEP.
REQ-018 Opcode 00 READ (IDLE): probe[arg] captured on acceptance edge; arg >= NUM_PROBES captures 0; -> SEND with PROBE_W/8 bytes, LSB byte first.
REQ-019 Opcode 01 STEP (IDLE): N = arg, arg=0 treated as 1; -> STEP; cpu_en high exactly N consecutive cycles starting the cycle after acceptance; then -> SEND with one byte 0xA5.
REQ-020 Opcode 10 RUN (IDLE, arg[0]=1): -> SEND 0xA5, then RUN; arg[0]=0 in IDLE: SEND 0xA5, remain halted.
REQ-021 In RUN: cpu_en = NOT(bp_armed AND pc_in == bp_addr), combinational; processor stops with PC equal to breakpoint.
REQ-022 In RUN, breakpoint match: next edge -> SEND one byte 0xBB; bp_armed stays 1.
REQ-023 In RUN, HALT (opcode 10, arg[0]=0): cpu_en 0 from next cycle; -> SEND 0xA5.
REQ-024 In RUN, all other commands consumed and discarded; no response.
REQ-025 Simultaneous HALT acceptance and breakpoint match: breakpoint wins; single byte 0xBB.
REQ-026 Opcode 11 BP (IDLE): arg[0]=0 clears bp_armed, SEND 0xA5; arg[0]=1 -> BP_LOAD.
REQ-027 BP_LOAD: next PC_W/8 accepted cmd_code bytes form bp_addr, LSB first; after last byte set bp_armed, SEND 0xA5.
REQ-028 SEND: tx_valid=1, tx_data = current byte; advance on tx_ready; after last byte -> IDLE, or RUN if entered via RUN command.
REQ-029 tx_data/tx_valid SHALL be registered, stable while tx_valid && !tx_ready.
REQ-030 cpu_en SHALL be 0 in all states except STEP and RUN.
REQ-031 Byte counters SHALL wrap to 0 on completion; no partial-response carryover.

Reset
REQ-032 Asynchronous assertion (reset=0) SHALL immediately force IDLE, cpu_en=0, tx_valid=0, tx_data=0, halted=1, bp_armed=0, bp_addr=0, counters=0.
REQ-033 Reset mid-SEND/STEP/BP_LOAD SHALL abort the operation; no byte emitted after release until new command.
REQ-034 After release, first command SHALL be accepted on first edge with cmd_valid=1.

Verification
REQ-035 READ: probe 5 = 0x12345678, cmd 0x05, tx_ready=1 -> bytes 78,56,34,12, then IDLE.
REQ-036 READ out of range: NUM_PROBES=32, cmd 0x3F -> 00,00,00,00.
REQ-037 STEP: cmd 0x43 -> cpu_en high exactly 3 cycles, then byte A5; cmd 0x40 -> 1 cycle, A5.
REQ-038 Breakpoint: cmd 0xC1, bytes 40,00,00,00, RUN cmd 0x81, pc_in counts by 4 from 0 -> A5, A5, cpu_en low when pc_in=0x40, byte BB, halted=1.
REQ-039 Backpressure: READ with tx_ready low 5 cycles -> tx_data held 0x78, cmd_ready=0 throughout.
REQ-040 Reset during STEP 0x4A after 4 cycles -> cpu_en=0 immediately, no A5 emitted, bp_armed=0.
